// File: rtl/ray_frame_sequencer.sv
// rtl/ray_frame_sequencer.sv - raster-scan ray launcher and shade sampler for the ray-march core
// Optional build macro: RAY_SEQ_GRADIENT_BG_EN (vertical sky ramp on misses).
module ray_frame_sequencer #(
    parameter int          H_RES       = 160,
    parameter int          V_RES       = 120,
    parameter int          MARCH_STEPS = 24,
    parameter int          DIR_SHIFT   = 2,
    parameter logic [15:0] DIR_Z       = 16'h0100,
    parameter logic [15:0] ORIGIN_Z    = 16'hFC00,
    parameter logic [7:0]  BACKGROUND  = 8'd16,
    localparam int         XW          = $clog2(H_RES),
    localparam int         YW          = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_go,
    input  logic [15:0]   light_in_x,
    input  logic [15:0]   light_in_y,
    input  logic [15:0]   light_in_z,
    output logic          busy,
    output logic          start,
    output logic [15:0]   origin_x,
    output logic [15:0]   origin_y,
    output logic [15:0]   origin_z,
    output logic [15:0]   dir_x,
    output logic [15:0]   dir_y,
    output logic [15:0]   dir_z,
    output logic [15:0]   light_x,
    output logic [15:0]   light_y,
    output logic [15:0]   light_z,
    input  logic          surface_hit,
    input  logic [15:0]   intensity,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [7:0]    pix_data,
    output logic          pix_last
);

    localparam int            CW     = $clog2(MARCH_STEPS);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(MARCH_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_MARCH  = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          start_q, start_d;
    logic [15:0]   dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
    logic [15:0]   light_x_q, light_x_d, light_y_q, light_y_d, light_z_q, light_z_d;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_last_q, pix_last_d;
    logic [7:0]    pix_data_q, pix_data_d;
    logic [16:0]   off_x, off_y, shl_x, shl_y;
    logic [7:0]    shade;

`ifdef RAY_SEQ_GRADIENT_BG_EN
    logic [7:0] row8;
    logic [8:0] ramp;
`endif

    // Hit shade saturates signed Q8.8 intensity into 0..255.
    always_comb begin
        if (surface_hit) begin
            if (intensity[15])
                shade = 8'h00;
            else if (intensity[14:8] != 7'd0)
                shade = 8'hFF;
            else
                shade = intensity[7:0];
        end else begin
`ifdef RAY_SEQ_GRADIENT_BG_EN
            row8  = 8'(py_q);
            ramp  = {1'b0, BACKGROUND} + {1'b0, row8};
            shade = ramp[8] ? 8'hFF : ramp[7:0];
`else
            shade = BACKGROUND;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        dir_z_d     = dir_z_q;
        light_x_d   = light_x_q;
        light_y_d   = light_y_q;
        light_z_d   = light_z_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        pix_data_d  = pix_data_q;

        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    light_x_d = light_in_x;
                    light_y_d = light_in_y;
                    light_z_d = light_in_z;
                    px_d      = '0;
                    py_d      = '0;
                    busy_d    = 1'b1;
                    start_d   = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_MARCH;
            end
            S_MARCH: begin
                if (cnt_q == C_LAST) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = shade;
                    pix_last_d  = (px_q == X_LAST) && (py_q == Y_LAST);
                    state_d     = S_EMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    if (pix_last_q) begin
                        px_d    = '0;
                        py_d    = '0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        if (px_q == X_LAST) begin
                            px_d = '0;
                            py_d = py_q + YW'(1);
                        end else begin
                            px_d = px_q + XW'(1);
                        end
                        start_d = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Direction is registered alongside start so it is valid in the launch cycle.
        off_x = 17'(px_d) - 17'(H_RES / 2);
        off_y = 17'(V_RES / 2) - 17'(py_d);
        shl_x = off_x << DIR_SHIFT;
        shl_y = off_y << DIR_SHIFT;
        if (start_d) begin
            dir_x_d = shl_x[15:0];
            dir_y_d = shl_y[15:0];
            dir_z_d = DIR_Z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            px_q        <= '0;
            py_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            dir_x_q     <= '0;
            dir_y_q     <= '0;
            dir_z_q     <= '0;
            light_x_q   <= '0;
            light_y_q   <= '0;
            light_z_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            dir_z_q     <= dir_z_d;
            light_x_q   <= light_x_d;
            light_y_q   <= light_y_d;
            light_z_q   <= light_z_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign busy      = busy_q;
    assign start     = start_q;
    assign origin_x  = 16'h0000;
    assign origin_y  = 16'h0000;
    assign origin_z  = ORIGIN_Z;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign dir_z     = dir_z_q;
    assign light_x   = light_x_q;
    assign light_y   = light_y_q;
    assign light_z   = light_z_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_data  = pix_data_q;
    assign pix_last  = pix_last_q;

endmodule

// File: tb/tb_ray_frame_sequencer.sv
// tb/tb_ray_frame_sequencer.sv - randomized self-checking bench for ray_frame_sequencer
module tb_ray_frame_sequencer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int MS = 3;
    localparam int DS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_go;
    logic [15:0] light_in_x, light_in_y, light_in_z;
    logic        busy, start;
    logic [15:0] origin_x, origin_y, origin_z;
    logic [15:0] dir_x, dir_y, dir_z;
    logic [15:0] light_x, light_y, light_z;
    logic        surface_hit;
    logic [15:0] intensity;
    logic        pix_valid, pix_ready;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic [7:0]  pix_data;
    logic        pix_last;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ray_frame_sequencer #(
        .H_RES(H), .V_RES(V), .MARCH_STEPS(MS), .DIR_SHIFT(DS)
    ) dut (
        .clk(clk), .rst(rst), .frame_go(frame_go),
        .light_in_x(light_in_x), .light_in_y(light_in_y), .light_in_z(light_in_z),
        .busy(busy), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .origin_z(origin_z),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
        .light_x(light_x), .light_y(light_y), .light_z(light_z),
        .surface_hit(surface_hit), .intensity(intensity),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_last(pix_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_shade(input bit hit, input logic [15:0] v, input int row);
        int s;
        s = $signed(v);
        if (hit) begin
            if (s < 0)   return 0;
            if (s > 255) return 255;
            return s;
        end
`ifdef RAY_SEQ_GRADIENT_BG_EN
        return (16 + row > 255) ? 255 : 16 + row;
`else
        return 16;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {start, busy, pix_valid, pix_last}, 0);
        chk({tag, "_pix"}, {pix_x, pix_y, pix_data}, 0);
        chk({tag, "_dir"}, {dir_x, dir_y}, 0);
        chk({tag, "_dirz"}, dir_z, 0);
        chk({tag, "_light"}, {light_x, light_y}, 0);
        chk({tag, "_lightz"}, light_z, 0);
        chk({tag, "_origin"}, {origin_x, origin_y}, 0);
        chk({tag, "_originz"}, origin_z, 16'hFC00);
    endtask

    // mode 0: always hit with 0x0080; mode 1: random hit/intensity.
    // stall_max < 0 means a fixed stall of -stall_max cycles on every pixel.
    task automatic do_frame(input int mode, input int stall_max, input int abort_at, input bit disturb);
        logic [15:0] lx, ly, lz, inten;
        bit          hit;
        int          prev_start, prev_stall, n, s, exp_sh;
        lx = 16'($urandom); ly = 16'($urandom); lz = 16'($urandom);
        light_in_x = lx; light_in_y = ly; light_in_z = lz;
        frame_go   = 1'b1;
        prev_start = 0;
        prev_stall = 0;
        @(negedge clk);
        frame_go = 1'b0;
        for (int i = 0; i < H * V; i++) begin
            int ex_x = i % H;
            int ex_y = i / H;
            n = 0;
            while (!start && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!start) begin
                chk("start_timeout", 0, 1);
                return;
            end
            if (i > 0) chk("start_spacing", cyc - prev_start, MS + 2 + prev_stall);
            prev_start = cyc;
            chk("dir_x", dir_x, ((ex_x - H / 2) * (1 << DS)) & 16'hFFFF);
            chk("dir_y", dir_y, ((V / 2 - ex_y) * (1 << DS)) & 16'hFFFF);
            chk("dir_z", dir_z, 16'h0100);
            chk("origin", {origin_x, origin_y, origin_z}, {16'h0, 16'h0, 16'hFC00});
            chk("light_xy", {light_x, light_y}, {lx, ly});
            chk("light_z", light_z, lz);
            chk("busy_frame", busy, 1);
            if (mode == 0) begin
                hit = 1'b1;
                inten = 16'h0080;
            end else begin
                hit = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 5))
                    0: inten = 16'h0080;
                    1: inten = 16'hFF00;
                    2: inten = 16'h0200;
                    3: inten = 16'h00FF;
                    4: inten = 16'h0100;
                    default: inten = 16'($urandom);
                endcase
            end
            surface_hit = hit;
            intensity   = inten;
            exp_sh      = ref_shade(hit, inten, ex_y);
            pix_ready   = 1'($urandom_range(0, 1));
            if (disturb && i == 2) begin
                frame_go   = 1'b1;
                light_in_x = ~lx; light_in_y = ~ly; light_in_z = ~lz;
            end
            if (i == abort_at) begin
                @(negedge clk);
                frame_go = 1'b0;
                rst      = 1'b1;
                @(negedge clk);
                check_reset_outputs("abort");
                rst = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    chk("idle_after_abort", {start, busy, pix_valid}, 0);
                end
                return;
            end
            n = 0;
            do begin
                @(negedge clk);
                frame_go = 1'b0;
                n++;
                if (!pix_valid) chk("no_start_in_march", start, 0);
            end while (!pix_valid && n < 40);
            chk("valid_latency", n, MS + 1);
            if (!pix_valid) return;
            chk("pix_xy", {pix_x, pix_y}, {2'(ex_x), 1'(ex_y)});
            chk("pix_data", pix_data, exp_sh);
            chk("pix_last", pix_last, (i == H * V - 1) ? 1 : 0);
            s = (stall_max < 0) ? -stall_max : ((stall_max > 0) ? $urandom_range(0, stall_max) : 0);
            pix_ready = (s == 0);
            for (int k = 0; k < s; k++) begin
                @(negedge clk);
                chk("stall_stable", {pix_valid, start, pix_last, pix_data, pix_y, pix_x},
                    {1'b1, 1'b0, (i == H * V - 1) ? 1'b1 : 1'b0, 8'(exp_sh), 1'(ex_y), 2'(ex_x)});
                if (k == s - 1) pix_ready = 1'b1;
            end
            prev_stall = s;
            @(negedge clk);
            if (i == H * V - 1) begin
                chk("frame_end", {busy, pix_valid, start}, 0);
                chk("light_hold_end", light_x, lx);
            end else begin
                chk("next_launch", {start, pix_valid}, 2'b10);
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_go = 1'b0; pix_ready = 1'b0;
        light_in_x = '0; light_in_y = '0; light_in_z = '0;
        surface_hit = 1'b0; intensity = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_go", {busy, start, pix_valid}, 0);

        do_frame(0, 0, -1, 1'b0);
        do_frame(1, 3, -1, 1'b1);
        do_frame(1, -7, -1, 1'b0);
        do_frame(1, 2, 2, 1'b0);
        do_frame(1, 2, -1, 1'b1);
        for (int f = 0; f < 4; f++) do_frame(1, 4, -1, f[0]);

        repeat (3) @(negedge clk);
        chk("final_idle", {busy, start, pix_valid}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
